// File: rtl/microcode_pkg.sv
// Control-word encoding for the microcode store. The ROM generator and the sequencer both
// import this package, so the field layout and plane codes have a single definition.
package microcode_pkg;

    typedef enum logic [3:0] {
        OUT_NONE      = 4'd0,
        OUT_REG       = 4'd1,
        OUT_TMP0      = 4'd2,
        OUT_TMP1      = 4'd3,
        OUT_MMU       = 4'd4,
        OUT_MLU       = 4'd5,
        OUT_SHIFTER   = 4'd6,
        OUT_TIMER     = 4'd7,
        OUT_CTRL_DATA = 4'd8
    } out_plane_e;

    typedef enum logic [2:0] {
        IN_NONE   = 3'd0,
        IN_REG    = 3'd1,
        IN_TMP0   = 3'd2,
        IN_TMP1   = 3'd3,
        IN_MMU    = 3'd4,
        IN_OPWORD = 3'd5,
        IN_OPCODE = 3'd6
    } in_plane_e;

    typedef enum logic [1:0] {
        REG_SEL_RD   = 2'd0,
        REG_SEL_RS   = 2'd1,
        REG_SEL_CTRL = 2'd2,
        REG_SEL_ZERO = 2'd3
    } reg_sel_e;

    localparam logic MISC_RESET_MICROOP_COUNTER = 1'b1;
    localparam logic OPCODE_SEL_OPCODE_FROM_BUS = 1'b1;

    localparam logic [5:0] OP_RESET = 6'd0;
    localparam logic [5:0] OP_FETCH = 6'd1;
    localparam logic [5:0] OP_LW    = 6'd2;

    // Control word layout; bits [31:23] are reserved and ignored.
    localparam int unsigned CTRL_LSB       = 0;
    localparam int unsigned CTRL_W         = 6;
    localparam int unsigned REG_SEL_LSB    = 6;
    localparam int unsigned REG_SEL_W      = 2;
    localparam int unsigned OUT_LSB        = 8;
    localparam int unsigned OUT_W          = 4;
    localparam int unsigned IN_LSB         = 12;
    localparam int unsigned IN_W           = 3;
    localparam int unsigned MISC_BIT       = 15;
    localparam int unsigned MLU_LSB        = 16;
    localparam int unsigned MLU_W          = 4;
    localparam int unsigned SHIFT_LSB      = 20;
    localparam int unsigned SHIFT_W        = 2;
    localparam int unsigned OPCODE_SEL_BIT = 22;

endpackage

// File: rtl/plane_decoder.sv
// Combinational decode of the control word into one-hot bus/latch enables and register select.
// Everything is forced to zero unless the sequencer is running; latch enables also drop on stall.
module plane_decoder
    import microcode_pkg::*;
(
    input  logic [31:0] mc_data_i,
    input  logic [31:0] opword_i,
    input  logic        run_i,
    input  logic        stall_i,
    output logic [8:0]  out_en_o,
    output logic [6:0]  in_en_o,
    output logic [4:0]  reg_idx_o
);

    logic [OUT_W-1:0]     out_code;
    logic [IN_W-1:0]      in_code;
    logic [REG_SEL_W-1:0] reg_sel;
    logic                 unused_bits;

    assign out_code    = mc_data_i[OUT_LSB +: OUT_W];
    assign in_code     = mc_data_i[IN_LSB +: IN_W];
    assign reg_sel     = mc_data_i[REG_SEL_LSB +: REG_SEL_W];
    assign unused_bits = ^{mc_data_i[31:15], mc_data_i[5], opword_i[31:26], opword_i[15:0]};

    always_comb begin
        out_en_o  = '0;
        in_en_o   = '0;
        reg_idx_o = '0;
        if (run_i) begin
            // Codes past the defined set leave the enables all-zero.
            if (out_code != OUT_NONE && out_code <= OUT_CTRL_DATA) begin
                out_en_o[out_code] = 1'b1;
            end
            if (!stall_i && in_code != IN_NONE && in_code <= IN_OPCODE) begin
                in_en_o[in_code] = 1'b1;
            end
            case (reg_sel)
                REG_SEL_RD:   reg_idx_o = opword_i[25:21];
                REG_SEL_RS:   reg_idx_o = opword_i[20:16];
                REG_SEL_CTRL: reg_idx_o = mc_data_i[CTRL_LSB +: 5];
                REG_SEL_ZERO: reg_idx_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: opcode register and micro-op counter address the ROM; the returned
// control word is split into datapath planes. Execution is held off until bootstrap completes.
module microcode_sequencer
    import microcode_pkg::*;
#(
    parameter int unsigned OPCODE_W      = 6,
    parameter int unsigned UOP_W         = 5,
    parameter bit          FAULT_ON_WRAP = 1'b1
) (
    input  logic                      CLK,
    input  logic                      N_RST,
    input  logic                      N_BOOTED,
    input  logic                      STALL,
    output logic [OPCODE_W+UOP_W-1:0] MC_ADDR,
    input  logic [31:0]               MC_DATA,
    input  logic [31:0]               OPWORD,
    input  logic [31:0]               BUS,
    output logic [5:0]                CTRL_DATA,
    output logic [4:0]                REG_IDX,
    output logic [8:0]                OUT_EN,
    output logic [6:0]                IN_EN,
    output logic [3:0]                MLU_OP,
    output logic [1:0]                SHIFT_OP,
    output logic                      FAULT
);

    typedef enum logic [1:0] {S_WAIT_BOOT, S_RUN, S_FAULT} state_e;

    state_e              state_q;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [UOP_W-1:0]    count_q, count_d;
    logic                fault_q;
    logic                run, misc, overflow, load_opcode;
    logic                unused_bits;

    assign run         = (state_q == S_RUN);
    assign misc        = (MC_DATA[MISC_BIT] == MISC_RESET_MICROOP_COUNTER);
    assign overflow    = (count_q == '1) && !misc;
    // The opcode is held across a counter overflow even if the word asks to load it.
    assign load_opcode = (MC_DATA[IN_LSB +: IN_W] == IN_OPCODE) && !overflow;
    assign unused_bits = ^BUS[31:OPCODE_W];

    always_comb begin
        count_d  = misc ? '0 : count_q + UOP_W'(1);
        opcode_d = opcode_q;
        if (load_opcode) begin
            opcode_d = (MC_DATA[OPCODE_SEL_BIT] == OPCODE_SEL_OPCODE_FROM_BUS)
                     ? BUS[OPCODE_W-1:0] : OPWORD[31 -: OPCODE_W];
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q  <= S_WAIT_BOOT;
            opcode_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT_BOOT: begin
                    if (!N_BOOTED) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (N_BOOTED) begin
                        state_q  <= S_WAIT_BOOT;
                        opcode_q <= '0;
                        count_q  <= '0;
                    end else if (!STALL) begin
                        if (overflow && FAULT_ON_WRAP) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                            count_q <= '0;
                        end else begin
                            count_q  <= count_d;
                            opcode_q <= opcode_d;
                        end
                    end
                end
                S_FAULT: begin
                    if (N_BOOTED) begin
                        state_q  <= S_WAIT_BOOT;
                        opcode_q <= '0;
                        count_q  <= '0;
                    end
                end
                default: state_q <= S_WAIT_BOOT;
            endcase
        end
    end

    plane_decoder u_plane_decoder (
        .mc_data_i (MC_DATA),
        .opword_i  (OPWORD),
        .run_i     (run),
        .stall_i   (STALL),
        .out_en_o  (OUT_EN),
        .in_en_o   (IN_EN),
        .reg_idx_o (REG_IDX)
    );

    assign MC_ADDR   = {opcode_q, count_q};
    assign CTRL_DATA = run ? MC_DATA[CTRL_LSB +: CTRL_W]  : '0;
    assign MLU_OP    = run ? MC_DATA[MLU_LSB +: MLU_W]    : '0;
    assign SHIFT_OP  = run ? MC_DATA[SHIFT_LSB +: SHIFT_W] : '0;
    assign FAULT     = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: boot gating, reset microcode, fetch decode, stall,
// counter overflow (fault and wrap variants) and asynchronous reset.
module tb_microcode_sequencer;

    logic        CLK = 1'b0;
    logic        N_RST, N_BOOTED, STALL;
    logic [31:0] MC_DATA, OPWORD, BUS;

    logic [10:0] mc_addr, mc_addr_w;
    logic [5:0]  ctrl_data, ctrl_data_w;
    logic [4:0]  reg_idx, reg_idx_w;
    logic [8:0]  out_en, out_en_w;
    logic [6:0]  in_en, in_en_w;
    logic [3:0]  mlu_op, mlu_op_w;
    logic [1:0]  shift_op, shift_op_w;
    logic        fault, fault_w;

    int tests_run = 0;
    int fails     = 0;

    always #5 CLK = ~CLK;

    microcode_sequencer #(.OPCODE_W(6), .UOP_W(5), .FAULT_ON_WRAP(1'b1)) dut (
        .CLK(CLK), .N_RST(N_RST), .N_BOOTED(N_BOOTED), .STALL(STALL),
        .MC_ADDR(mc_addr), .MC_DATA(MC_DATA), .OPWORD(OPWORD), .BUS(BUS),
        .CTRL_DATA(ctrl_data), .REG_IDX(reg_idx), .OUT_EN(out_en), .IN_EN(in_en),
        .MLU_OP(mlu_op), .SHIFT_OP(shift_op), .FAULT(fault)
    );

    microcode_sequencer #(.OPCODE_W(6), .UOP_W(5), .FAULT_ON_WRAP(1'b0)) dut_w (
        .CLK(CLK), .N_RST(N_RST), .N_BOOTED(N_BOOTED), .STALL(STALL),
        .MC_ADDR(mc_addr_w), .MC_DATA(MC_DATA), .OPWORD(OPWORD), .BUS(BUS),
        .CTRL_DATA(ctrl_data_w), .REG_IDX(reg_idx_w), .OUT_EN(out_en_w), .IN_EN(in_en_w),
        .MLU_OP(mlu_op_w), .SHIFT_OP(shift_op_w), .FAULT(fault_w)
    );

    // Control word: [22] opcode_sel, [21:20] shift, [19:16] mlu, [15] misc, [14:12] in,
    // [11:8] out, [7:6] reg_sel, [5:0] ctrl; reserved top bits carry junk.
    function automatic logic [31:0] mk(input logic [5:0] ctrl, input logic [1:0] sel,
                                       input logic [3:0] outp, input logic [2:0] inp,
                                       input logic misc, input logic osel,
                                       input logic [3:0] mlu, input logic [1:0] sh);
        mk = {9'h1A5, osel, sh, mlu, misc, inp, outp, sel, ctrl};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        N_RST = 1'b1; N_BOOTED = 1'b1; STALL = 1'b0;
        OPWORD = '0; BUS = '0;
        MC_DATA = mk(6'd9, 2'd2, 4'd1, 3'd1, 1'b0, 1'b0, 4'h5, 2'd3);
        #2 N_RST = 1'b0;
        #2;
        tests_run++;
        if ({mc_addr, out_en, in_en, ctrl_data, reg_idx, mlu_op, shift_op, fault} !== 45'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {mc_addr, out_en, in_en, ctrl_data, reg_idx, mlu_op, shift_op, fault});
        end
        tick();
        N_RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({mc_addr, out_en, in_en} !== 27'd0) begin
                fails++;
                $display("FAIL boot_wait[%0d]: got addr=%h out=%h in=%h expected all 0",
                         i, mc_addr, out_en, in_en);
            end
        end
        N_BOOTED = 1'b0;
        #1;
        tests_run++;
        if (out_en !== 9'h000) begin
            fails++;
            $display("FAIL boot_pre_edge: got out=%h expected 000", out_en);
        end
        tick();
        tests_run++;
        if ({mc_addr, out_en, in_en, reg_idx, mlu_op, shift_op} !==
            {11'h000, 9'h002, 7'h02, 5'd9, 4'h5, 2'd3}) begin
            fails++;
            $display("FAIL first_run: got addr=%h out=%h in=%h idx=%0d mlu=%h sh=%0d expected 000 002 02 9 5 3",
                     mc_addr, out_en, in_en, reg_idx, mlu_op, shift_op);
        end
    endtask

    task automatic test_reset_microcode();
        MC_DATA = mk(6'd31, 2'd2, 4'd0, 3'd1, 1'b0, 1'b0, 4'h0, 2'd0);
        #1;
        tests_run++;
        if ({reg_idx, in_en} !== {5'd31, 7'h02}) begin
            fails++;
            $display("FAIL rst_uc_addr0: got idx=%0d in=%h expected 31 02", reg_idx, in_en);
        end
        tick();
        tests_run++;
        if (mc_addr !== 11'h001) begin
            fails++;
            $display("FAIL rst_uc_advance: got %h expected 001", mc_addr);
        end
        BUS = 32'h0000_0001;
        MC_DATA = mk(6'd1, 2'd0, 4'd8, 3'd6, 1'b1, 1'b1, 4'h0, 2'd0);
        #1;
        tests_run++;
        if ({out_en, in_en, ctrl_data} !== {9'h100, 7'h40, 6'd1}) begin
            fails++;
            $display("FAIL rst_uc_addr1: got out=%h in=%h ctrl=%h expected 100 40 01",
                     out_en, in_en, ctrl_data);
        end
        tick();
        tests_run++;
        if (mc_addr !== 11'h020) begin
            fails++;
            $display("FAIL rst_uc_jump: got %h expected 020", mc_addr);
        end
    endtask

    task automatic test_fetch_decode();
        OPWORD = 32'h08A3_0000;
        BUS = 32'h0000_003F;
        MC_DATA = mk(6'd0, 2'd0, 4'd0, 3'd6, 1'b1, 1'b0, 4'h0, 2'd0);
        #1;
        tests_run++;
        if (reg_idx !== 5'd5) begin
            fails++;
            $display("FAIL fetch_rd: got %0d expected 5", reg_idx);
        end
        tick();
        tests_run++;
        if (mc_addr !== 11'h040) begin
            fails++;
            $display("FAIL fetch_dispatch: got %h expected 040", mc_addr);
        end
        MC_DATA = mk(6'd0, 2'd1, 4'd5, 3'd3, 1'b0, 1'b0, 4'hA, 2'd2);
        #1;
        tests_run++;
        if ({reg_idx, out_en, in_en, mlu_op, shift_op} !== {5'd3, 9'h020, 7'h08, 4'hA, 2'd2}) begin
            fails++;
            $display("FAIL decode_rs_mlu: got idx=%0d out=%h in=%h mlu=%h sh=%0d expected 3 020 08 a 2",
                     reg_idx, out_en, in_en, mlu_op, shift_op);
        end
        MC_DATA = mk(6'h2A, 2'd3, 4'hC, 3'd7, 1'b0, 1'b0, 4'h0, 2'd0);
        #1;
        tests_run++;
        if ({reg_idx, out_en, in_en, ctrl_data} !== {5'd0, 9'h000, 7'h00, 6'h2A}) begin
            fails++;
            $display("FAIL decode_undef: got idx=%0d out=%h in=%h ctrl=%h expected 0 000 00 2a",
                     reg_idx, out_en, in_en, ctrl_data);
        end
        tick();
        tick();
        tests_run++;
        if (mc_addr !== 11'h042) begin
            fails++;
            $display("FAIL count_to_2: got %h expected 042", mc_addr);
        end
    endtask

    task automatic test_stall();
        MC_DATA = mk(6'd0, 2'd0, 4'd2, 3'd1, 1'b0, 1'b0, 4'h0, 2'd0);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({in_en, out_en} !== {7'h00, 9'h004}) begin
                fails++;
                $display("FAIL stall_en[%0d]: got in=%h out=%h expected 00 004", i, in_en, out_en);
            end
            tick();
            tests_run++;
            if (mc_addr !== 11'h042) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got %h expected 042", i, mc_addr);
            end
        end
        STALL = 1'b0;
        #1;
        tests_run++;
        if (in_en !== 7'h02) begin
            fails++;
            $display("FAIL stall_release_en: got %h expected 02", in_en);
        end
        tick();
        tests_run++;
        if (mc_addr !== 11'h043) begin
            fails++;
            $display("FAIL stall_release_adv: got %h expected 043", mc_addr);
        end
    endtask

    task automatic test_overflow();
        MC_DATA = mk(6'd0, 2'd0, 4'd1, 3'd1, 1'b0, 1'b0, 4'h0, 2'd0);
        repeat (28) tick();
        tests_run++;
        if ({mc_addr, mc_addr_w, fault, fault_w} !== {11'h05F, 11'h05F, 2'b00}) begin
            fails++;
            $display("FAIL ovf_last: got %h %h fault=%b%b expected 05f 05f 00",
                     mc_addr, mc_addr_w, fault, fault_w);
        end
        BUS = 32'h0000_003F;
        MC_DATA = mk(6'd0, 2'd0, 4'd1, 3'd6, 1'b0, 1'b1, 4'h0, 2'd0);
        tick();
        tests_run++;
        if ({fault, out_en, in_en, mc_addr} !== {1'b1, 9'h000, 7'h00, 11'h040}) begin
            fault_report: begin
                fails++;
                $display("FAIL ovf_fault: got fault=%b out=%h in=%h addr=%h expected 1 000 00 040",
                         fault, out_en, in_en, mc_addr);
            end
        end
        tests_run++;
        if ({fault_w, mc_addr_w, out_en_w} !== {1'b0, 11'h040, 9'h002}) begin
            fails++;
            $display("FAIL ovf_wrap: got fault=%b addr=%h out=%h expected 0 040 002",
                     fault_w, mc_addr_w, out_en_w);
        end
        MC_DATA = mk(6'd0, 2'd0, 4'd1, 3'd1, 1'b0, 1'b0, 4'h0, 2'd0);
        repeat (3) tick();
        tests_run++;
        if ({fault, out_en, in_en, mc_addr} !== {1'b1, 9'h000, 7'h00, 11'h040}) begin
            fails++;
            $display("FAIL fault_sticky: got fault=%b out=%h in=%h addr=%h expected 1 000 00 040",
                     fault, out_en, in_en, mc_addr);
        end
        tests_run++;
        if ({fault_w, mc_addr_w} !== {1'b0, 11'h043}) begin
            fails++;
            $display("FAIL wrap_continue: got fault=%b addr=%h expected 0 043", fault_w, mc_addr_w);
        end
    endtask

    task automatic test_async_reset();
        tests_run++;
        if (in_en_w !== 7'h02) begin
            fails++;
            $display("FAIL arst_pre: got %h expected 02", in_en_w);
        end
        #2 N_RST = 1'b0;
        #1;
        tests_run++;
        if ({mc_addr, out_en, in_en, fault, mc_addr_w, out_en_w, in_en_w, reg_idx_w, mlu_op_w} !== 63'd0) begin
            fails++;
            $display("FAIL arst_immediate: got %h %h %h %b %h %h %h expected all 0",
                     mc_addr, out_en, in_en, fault, mc_addr_w, out_en_w, in_en_w);
        end
        tick();
        N_BOOTED = 1'b1;
        N_RST = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({mc_addr, out_en, in_en, fault} !== 28'd0) begin
            fails++;
            $display("FAIL arst_wait_boot: got addr=%h out=%h in=%h fault=%b expected all 0",
                     mc_addr, out_en, in_en, fault);
        end
        N_BOOTED = 1'b0;
        tick();
        tests_run++;
        if ({out_en, fault} !== {9'h002, 1'b0}) begin
            fails++;
            $display("FAIL arst_reboot: got out=%h fault=%b expected 002 0", out_en, fault);
        end
        tick();
        tests_run++;
        if (mc_addr !== 11'h001) begin
            fails++;
            $display("FAIL arst_reboot_adv: got %h expected 001", mc_addr);
        end
    endtask

    task automatic test_unboot();
        N_BOOTED = 1'b1;
        tick();
        tests_run++;
        if ({mc_addr, out_en, in_en, mc_addr_w, out_en_w} !== 47'd0) begin
            fails++;
            $display("FAIL unboot: got %h %h %h %h %h expected all 0",
                     mc_addr, out_en, in_en, mc_addr_w, out_en_w);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_microcode();
        test_fetch_decode();
        test_stall();
        test_overflow();
        test_async_reset();
        test_unboot();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
